// File: rtl/svf_sc_ctrl.sv
// Switching-clock divider and configuration sequencer for the SC state-variable filter macro.
// New settings land only on sc_clk period boundaries; mode changes mute the output while it settles.
module svf_sc_ctrl #(
    parameter int unsigned      DIV_W      = 10,
    parameter logic [DIV_W-1:0] DIV_RST    = 10'd63,
    parameter logic [3:0]       Q_RST      = 4'd8,
    parameter int unsigned      SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [3:0]       cfg_q,
    input  logic [1:0]       cfg_mode,
    output logic             sc_clk,
    output logic [3:0]       q_code,
    output logic [1:0]       sel,
    output logic             mute,
    output logic             busy
);

    localparam int unsigned   SW        = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StPend   = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sc_q, sc_d;
    logic [3:0]       q_q, q_d;
    logic [1:0]       sel_q, sel_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic [3:0]       sh_q_q, sh_q_d;
    logic [1:0]       sh_mode_q, sh_mode_d;

    logic boundary;
    logic xfer;

    // Last cycle of a high phase: sc_clk falls on the next edge.
    assign boundary  = (cnt_q == div_q) && sc_q;
    // en drops out of RUN with priority, so a config offered in that cycle is refused.
    assign cfg_ready = (state_q == StIdle) || ((state_q == StRun) && en);
    assign xfer      = cfg_valid && cfg_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        sc_d      = sc_q;
        q_d       = q_q;
        sel_d     = sel_q;
        mute_d    = mute_q;
        settle_d  = settle_q;
        pend_d    = pend_q;
        sh_div_d  = sh_div_q;
        sh_q_d    = sh_q_q;
        sh_mode_d = sh_mode_q;

        if (state_q != StIdle) begin
            if (cnt_q == div_q) begin
                cnt_d = '0;
                sc_d  = ~sc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (xfer) begin
            sh_div_d  = cfg_div;
            sh_q_d    = cfg_q;
            sh_mode_d = cfg_mode;
        end

        // A pending shadow lands on the boundary whether we are pending or stopping.
        if (boundary && pend_q) begin
            div_d  = sh_div_q;
            q_d    = sh_q_q;
            sel_d  = sh_mode_q;
            pend_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                sc_d   = 1'b0;
                mute_d = 1'b1;
                if (xfer) begin
                    div_d = cfg_div;
                    q_d   = cfg_q;
                    sel_d = cfg_mode;
                end
                if (en) begin
                    state_d  = StSettle;
                    settle_d = SETTLE_LD;
                end
            end
            StSettle: begin
                if (!en) begin
                    state_d = boundary ? StIdle : StStop;
                    mute_d  = 1'b1;
                end else if (settle_q == '0) begin
                    state_d = StRun;
                    mute_d  = 1'b0;
                end else if (boundary) begin
                    settle_d = settle_q - 1'b1;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = boundary ? StIdle : StStop;
                    mute_d  = 1'b1;
                end else if (xfer) begin
                    state_d = StPend;
                    pend_d  = 1'b1;
                    if (cfg_mode != sel_q) mute_d = 1'b1;
                end
            end
            StPend: begin
                if (!en) begin
                    state_d = boundary ? StIdle : StStop;
                    mute_d  = 1'b1;
                end else if (boundary) begin
                    if (sh_mode_q != sel_q) begin
                        state_d  = StSettle;
                        settle_d = SETTLE_LD;
                        mute_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StStop: begin
                if (boundary) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StSettle) || (state_d == StPend) || (state_d == StStop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            sc_q      <= 1'b0;
            q_q       <= Q_RST;
            sel_q     <= 2'd0;
            mute_q    <= 1'b1;
            busy_q    <= 1'b0;
            settle_q  <= '0;
            pend_q    <= 1'b0;
            sh_div_q  <= '0;
            sh_q_q    <= '0;
            sh_mode_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sc_q      <= sc_d;
            q_q       <= q_d;
            sel_q     <= sel_d;
            mute_q    <= mute_d;
            busy_q    <= busy_d;
            settle_q  <= settle_d;
            pend_q    <= pend_d;
            sh_div_q  <= sh_div_d;
            sh_q_q    <= sh_q_d;
            sh_mode_q <= sh_mode_d;
        end
    end

    assign sc_clk = sc_q;
    assign q_code = q_q;
    assign sel    = sel_q;
    assign mute   = mute_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_svf_sc_ctrl.sv
// Self-checking bench for svf_sc_ctrl: randomized configs checked against phase lengths,
// settle durations and landing points derived from the divider and settle rules.
module tb_svf_sc_ctrl;

    localparam int unsigned DIV_W      = 10;
    localparam int unsigned SETTLE_CYC = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [3:0]       cfg_q = '0;
    logic [1:0]       cfg_mode = '0;
    logic             sc_clk;
    logic [3:0]       q_code;
    logic [1:0]       sel;
    logic             mute;
    logic             busy;

    svf_sc_ctrl #(
        .DIV_W     (DIV_W),
        .DIV_RST   (10'd63),
        .Q_RST     (4'd8),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_q    (cfg_q),
        .cfg_mode (cfg_mode),
        .sc_clk   (sc_clk),
        .q_code   (q_code),
        .sel      (sel),
        .mute     (mute),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic sc_prev = 1'b0;
    logic sc_cur  = 1'b0;

    // Reference configuration as the macro should currently see it.
    int         m_div;
    logic [3:0] m_q;
    logic [1:0] m_sel;

    task automatic sample();
        @(negedge clk);
        sc_prev = sc_cur;
        sc_cur  = sc_clk;
    endtask

    task automatic wait_edge(input bit rising, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            sample();
            n++;
            if (rising ? (!sc_prev && sc_cur) : (sc_prev && !sc_cur)) ok = 1'b1;
        end
    endtask

    task automatic drive_cfg(input int d, input logic [3:0] q, input logic [1:0] m);
        cfg_valid = 1'b1;
        cfg_div   = d[DIV_W-1:0];
        cfg_q     = q;
        cfg_mode  = m;
        sample();
        cfg_valid = 1'b0;
    endtask

    task automatic go_low();
        for (int k = 0; k < 20 && sc_cur; k++) sample();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) sample();
        n_cmp++; if (sc_clk !== 1'b0) begin n_err++; $display("FAIL reset_sc: got %b want 0", sc_clk); end
        n_cmp++; if (q_code !== 4'd8) begin n_err++; $display("FAIL reset_q: got %0d want 8", q_code); end
        n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_cmp++; if (mute !== 1'b1) begin n_err++; $display("FAIL reset_mute: got %b want 1", mute); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        rst_n = 1'b1;
        repeat (2) sample();
        n_cmp++; if (sc_clk !== 1'b0 || mute !== 1'b1) begin
            n_err++; $display("FAIL idle_hold: sc=%b mute=%b want 0/1", sc_clk, mute);
        end
        m_div = 63; m_q = 4'd8; m_sel = 2'd0;
    endtask

    task automatic test_default_settle();
        int i, falls, first_rise, first_fall, last_fall, drop;
        i = 0; falls = 0; first_rise = 0; first_fall = 0; last_fall = 0; drop = 0;
        en = 1'b1;
        while (drop == 0 && i < 3000) begin
            sample(); i++;
            if (!sc_prev && sc_cur && first_rise == 0) first_rise = i;
            if (sc_prev && !sc_cur) begin
                falls++; last_fall = i;
                if (first_fall == 0) first_fall = i;
            end
            if (!mute) drop = i;
        end
        n_cmp++; if (first_rise - 1 != m_div + 1) begin
            n_err++; $display("FAIL settle_low_phase: got %0d want %0d", first_rise - 1, m_div + 1);
        end
        n_cmp++; if (first_fall - first_rise != m_div + 1) begin
            n_err++; $display("FAIL settle_high_phase: got %0d want %0d", first_fall - first_rise, m_div + 1);
        end
        n_cmp++; if (falls != SETTLE_CYC) begin
            n_err++; $display("FAIL settle_periods: got %0d want %0d", falls, SETTLE_CYC);
        end
        n_cmp++; if (drop != last_fall + 1) begin
            n_err++; $display("FAIL settle_unmute_point: got %0d want %0d", drop, last_fall + 1);
        end
        n_cmp++; if (drop != 2 * (m_div + 1) * SETTLE_CYC + 2) begin
            n_err++; $display("FAIL settle_total: got %0d want %0d", drop, 2 * (m_div + 1) * SETTLE_CYC + 2);
        end
        n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL run_flags: busy=%b ready=%b want 0/1", busy, cfg_ready);
        end
    endtask

    task automatic test_cfg_div_q();
        int nd, n; bit ok; logic [3:0] nq;
        nd = $urandom_range(1, 6);
        nq = m_q + 4'($urandom_range(1, 15));
        wait_edge(1'b1, 300, n, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL divq_rise: timeout got none want edge"); end
        repeat (2) sample();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL divq_ready: got %b want 1", cfg_ready); end
        drive_cfg(nd, nq, m_sel);
        n_cmp++; if (cfg_ready !== 1'b0 || busy !== 1'b1 || mute !== 1'b0) begin
            n_err++; $display("FAIL divq_pend: ready=%b busy=%b mute=%b want 0/1/0", cfg_ready, busy, mute);
        end
        wait_edge(1'b0, 300, n, ok);
        n_cmp++; if (3 + n != m_div + 1) begin
            n_err++; $display("FAIL divq_old_high: got %0d want %0d", 3 + n, m_div + 1);
        end
        n_cmp++; if (q_code !== nq || mute !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL divq_land: q=%0d mute=%b busy=%b want %0d/0/0", q_code, mute, busy, nq);
        end
        m_div = nd; m_q = nq;
        wait_edge(1'b1, 50, n, ok);
        n_cmp++; if (n != m_div + 1) begin n_err++; $display("FAIL divq_new_low: got %0d want %0d", n, m_div + 1); end
        wait_edge(1'b0, 50, n, ok);
        n_cmp++; if (n != m_div + 1) begin n_err++; $display("FAIL divq_new_high: got %0d want %0d", n, m_div + 1); end
    endtask

    task automatic test_mode_change();
        int nd, n, i, falls, last, drop; bit ok; logic [3:0] nq; logic [1:0] nm;
        nd = $urandom_range(0, 3);
        nq = 4'($urandom_range(0, 15));
        nm = m_sel + 2'($urandom_range(1, 3));
        go_low();
        drive_cfg(nd, nq, nm);
        n_cmp++; if (mute !== 1'b1 || busy !== 1'b1 || sel !== m_sel) begin
            n_err++; $display("FAIL mode_accept: mute=%b busy=%b sel=%0d want 1/1/%0d", mute, busy, sel, m_sel);
        end
        wait_edge(1'b0, 50, n, ok);
        n_cmp++; if (!ok || sel !== nm || q_code !== nq) begin
            n_err++; $display("FAIL mode_land: sel=%0d q=%0d want %0d/%0d", sel, q_code, nm, nq);
        end
        i = 0; falls = 0; last = 0; drop = 0;
        while (drop == 0 && i < 2000) begin
            sample(); i++;
            if (sc_prev && !sc_cur) begin falls++; last = i; end
            if (!mute) drop = i;
        end
        n_cmp++; if (falls != SETTLE_CYC || last != 2 * (nd + 1) * SETTLE_CYC) begin
            n_err++; $display("FAIL mode_settle: falls=%0d at %0d want %0d at %0d", falls, last,
                              SETTLE_CYC, 2 * (nd + 1) * SETTLE_CYC);
        end
        n_cmp++; if (drop != last + 1) begin n_err++; $display("FAIL mode_unmute: got %0d want %0d", drop, last + 1); end
        m_div = nd; m_q = nq; m_sel = nm;
    endtask

    task automatic test_div0();
        int n; bit ok; logic [3:0] nq;
        nq = 4'($urandom_range(0, 15));
        go_low();
        drive_cfg(0, nq, m_sel);
        wait_edge(1'b0, 50, n, ok);
        n_cmp++; if (!ok || q_code !== nq) begin n_err++; $display("FAIL div0_land: q=%0d want %0d", q_code, nq); end
        m_div = 0; m_q = nq;
        wait_edge(1'b1, 10, n, ok);
        n_cmp++; if (n != 1) begin n_err++; $display("FAIL div0_low: got %0d want 1", n); end
        wait_edge(1'b0, 10, n, ok);
        n_cmp++; if (n != 1) begin n_err++; $display("FAIL div0_high: got %0d want 1", n); end
        drive_cfg(1, m_q, m_sel);
        n_cmp++; if (busy !== 1'b1 || sc_clk !== 1'b1) begin
            n_err++; $display("FAIL div1_pend: busy=%b sc=%b want 1/1", busy, sc_clk);
        end
        wait_edge(1'b0, 10, n, ok);
        n_cmp++; if (n != 1) begin n_err++; $display("FAIL div1_fall: got %0d want 1", n); end
        m_div = 1;
        wait_edge(1'b1, 10, n, ok);
        n_cmp++; if (n != 2) begin n_err++; $display("FAIL div1_low: got %0d want 2", n); end
        wait_edge(1'b0, 10, n, ok);
        n_cmp++; if (n != 2) begin n_err++; $display("FAIL div1_high: got %0d want 2", n); end
    endtask

    task automatic test_stop();
        int nd, nd2, n, highs; bit ok; logic [3:0] nq; logic [1:0] nm;
        nd = $urandom_range(4, 8);
        nq = 4'($urandom_range(0, 15));
        go_low();
        drive_cfg(nd, nq, m_sel);
        wait_edge(1'b0, 50, n, ok);
        m_div = nd; m_q = nq;
        wait_edge(1'b1, 50, n, ok);
        n_cmp++; if (!ok || n != m_div + 1) begin n_err++; $display("FAIL stop_pre_low: got %0d want %0d", n, m_div + 1); end
        sample();
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_q     = ~m_q;
        cfg_mode  = m_sel;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL stop_ready_gate: got %b want 0", cfg_ready); end
        sample();
        cfg_valid = 1'b0;
        n_cmp++; if (mute !== 1'b1 || busy !== 1'b1 || sc_clk !== 1'b1) begin
            n_err++; $display("FAIL stop_enter: mute=%b busy=%b sc=%b want 1/1/1", mute, busy, sc_clk);
        end
        wait_edge(1'b0, 50, n, ok);
        n_cmp++; if (2 + n != m_div + 1) begin n_err++; $display("FAIL stop_high: got %0d want %0d", 2 + n, m_div + 1); end
        n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || mute !== 1'b1 || q_code !== m_q) begin
            n_err++; $display("FAIL stop_idle: busy=%b ready=%b mute=%b q=%0d want 0/1/1/%0d",
                              busy, cfg_ready, mute, q_code, m_q);
        end
        highs = 0;
        repeat (2 * nd + 4) begin sample(); if (sc_cur) highs++; end
        n_cmp++; if (highs != 0) begin n_err++; $display("FAIL stop_hold_low: got %0d high want 0", highs); end
        nd2 = $urandom_range(2, 5);
        nq  = 4'($urandom_range(0, 15));
        nm  = 2'($urandom_range(0, 3));
        drive_cfg(nd2, nq, nm);
        n_cmp++; if (q_code !== nq || sel !== nm) begin
            n_err++; $display("FAIL idle_cfg: q=%0d sel=%0d want %0d/%0d", q_code, sel, nq, nm);
        end
        m_div = nd2; m_q = nq; m_sel = nm;
    endtask

    task automatic test_reset_pend();
        int i, drop; logic [3:0] nq;
        en = 1'b1;
        i = 0; drop = 0;
        while (drop == 0 && i < 1000) begin sample(); i++; if (!mute) drop = i; end
        n_cmp++; if (drop != 2 * (m_div + 1) * SETTLE_CYC + 2) begin
            n_err++; $display("FAIL resettest_settle: got %0d want %0d", drop, 2 * (m_div + 1) * SETTLE_CYC + 2);
        end
        go_low();
        nq = 4'($urandom_range(0, 7));
        drive_cfg($urandom_range(0, 5), nq, m_sel ^ 2'b01);
        n_cmp++; if (busy !== 1'b1 || mute !== 1'b1) begin
            n_err++; $display("FAIL resettest_pend: busy=%b mute=%b want 1/1", busy, mute);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (sc_clk !== 1'b0 || q_code !== 4'd8 || sel !== 2'd0) begin
            n_err++; $display("FAIL async_reset_cfg: sc=%b q=%0d sel=%0d want 0/8/0", sc_clk, q_code, sel);
        end
        n_cmp++; if (mute !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset_flags: mute=%b busy=%b ready=%b want 1/0/1", mute, busy, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sc_prev = 1'b0; sc_cur = 1'b0;
        m_div = 63; m_q = 4'd8; m_sel = 2'd0;
        i = 0; drop = 0;
        while (drop == 0 && i < 3000) begin sample(); i++; if (!mute) drop = i; end
        n_cmp++; if (drop != 2 * (m_div + 1) * SETTLE_CYC + 2) begin
            n_err++; $display("FAIL reenable_settle: got %0d want %0d", drop, 2 * (m_div + 1) * SETTLE_CYC + 2);
        end
        n_cmp++; if (q_code !== m_q || sel !== m_sel) begin
            n_err++; $display("FAIL shadow_discard: q=%0d sel=%0d want %0d/%0d", q_code, sel, m_q, m_sel);
        end
    endtask

    initial begin
        test_reset();
        test_default_settle();
        test_cfg_div_q();
        test_mode_change();
        test_div0();
        test_stop();
        test_reset_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
